// File: rtl/uart_rx_frame_ctrl.sv
// Framed-packet receiver: SYNC, LEN, payload, XOR checksum; holds a checked frame until acked.
// Optional inter-byte gap timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          MAX_LEN      = 15,
  parameter logic [15:0] TIMEOUT_CLKS = 16'd52080
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_error,
  input  logic       frame_ack,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_valid,
  output logic [3:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, HOLD} state_t;

  state_t     state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] csum_q, csum_d;
  logic       frame_valid_q, frame_valid_d;
  logic [3:0] frame_len_q, frame_len_d;
  logic       frame_err_q, frame_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       overrun_q, overrun_d;
  logic       mem_we;
  logic       timeout;

  logic [7:0] payload_mem [16];

`ifdef UART_FRAME_TIMEOUT_EN
  logic [15:0] gap_q, gap_d;

  // Counter restarts on every byte; fires on the TIMEOUT_CLKS-th idle cycle mid-frame.
  always_comb begin
    gap_d   = 16'd0;
    timeout = 1'b0;
    if ((state_q == LEN || state_q == PAYLOAD || state_q == CSUM) && !rx_done) begin
      if (gap_q == 16'(TIMEOUT_CLKS - 16'd1)) timeout = 1'b1;
      else                                     gap_d   = gap_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) gap_q <= 16'd0;
    else       gap_q <= gap_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    overrun_d     = 1'b0;
    mem_we        = 1'b0;

    case (state_q)
      HUNT: begin
        if (rx_done && !rx_error && rx_data == SYNC_BYTE) begin
          state_d = LEN;
          csum_d  = 8'd0;
        end
      end
      LEN, PAYLOAD, CSUM: begin
        if (rx_done && rx_error) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = HUNT;
        end else if (rx_done) begin
          case (state_q)
            LEN: begin
              if (rx_data == 8'd0) begin
                len_d   = 4'd0;
                csum_d  = 8'd0;
                state_d = CSUM;
              end else if (rx_data <= MAX_LEN_B) begin
                len_d   = rx_data[3:0];
                idx_d   = 4'd0;
                csum_d  = rx_data;
                state_d = PAYLOAD;
              end else begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd1;
                state_d     = HUNT;
              end
            end
            PAYLOAD: begin
              mem_we = 1'b1;
              csum_d = csum_q ^ rx_data;
              if (idx_q == len_q - 4'd1) state_d = CSUM;
              else                       idx_d   = idx_q + 4'd1;
            end
            CSUM: begin
              if (rx_data == csum_q) begin
                state_d       = HOLD;
                frame_valid_d = 1'b1;
                frame_len_d   = len_q;
              end else begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd0;
                state_d     = HUNT;
              end
            end
            default: ;
          endcase
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = HUNT;
        end
      end
      HOLD: begin
        // Bytes arriving while a frame is held are always dropped, even alongside an ack.
        if (rx_done) overrun_d = 1'b1;
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      len_q         <= 4'd0;
      idx_q         <= 4'd0;
      csum_q        <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= 4'd0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      overrun_q     <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) payload_mem[idx_q] <= rx_data;
  end

  assign rd_data     = payload_mem[rd_addr];
  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: queue-based frame model checked every cycle plus literal checks.
module tb_uart_rx_frame_ctrl;

  localparam int          MAXL = 15;
  localparam logic [15:0] TO   = 16'd300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [3:0] frame_len;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad = 0;

  uart_rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
    .frame_len(frame_len), .frame_err(frame_err), .err_code(err_code), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame in progress is a byte queue; rules applied to its length and contents.
  logic [7:0] pending[$];
  logic [7:0] exp_mem [16];
  bit         holding = 0;
  bit         exp_valid = 0, exp_err = 0, exp_ovr = 0, exp_busy = 0;
  logic [3:0] exp_len = 0;
  logic [1:0] exp_code = 0;
  int         gap = 0;

  task automatic model_fail(input logic [1:0] c);
    exp_err  = 1;
    exp_code = c;
    pending.delete();
  endtask

  task automatic model_step();
    int n, l;
    logic [7:0] x;
    exp_err = 0;
    exp_ovr = 0;
    if (reset) begin
      pending.delete();
      holding = 0; exp_valid = 0; exp_len = 0; exp_code = 0; gap = 0;
    end else if (holding) begin
      if (rx_done) exp_ovr = 1;
      if (frame_ack) begin holding = 0; exp_valid = 0; end
    end else if (pending.size() == 0) begin
      if (rx_done && !rx_error && rx_data == 8'hA5) pending.push_back(rx_data);
      gap = 0;
    end else if (rx_done) begin
      gap = 0;
      if (rx_error) model_fail(2'd2);
      else begin
        pending.push_back(rx_data);
        n = pending.size();
        if (n == 2) begin
          if (int'(rx_data) > MAXL) model_fail(2'd1);
        end else begin
          l = int'(pending[1]);
          if (n == l + 3) begin
            x = 8'd0;
            for (int i = 1; i < n - 1; i++) x ^= pending[i];
            if (x == rx_data) begin
              holding = 1; exp_valid = 1; exp_len = 4'(l);
              for (int i = 0; i < l; i++) exp_mem[i] = pending[i + 2];
              pending.delete();
            end else model_fail(2'd0);
          end
        end
      end
    end else begin
`ifdef UART_FRAME_TIMEOUT_EN
      gap++;
      if (gap == int'(TO)) begin model_fail(2'd3); gap = 0; end
`endif
    end
    exp_busy = holding || (pending.size() > 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_valid", 16'(frame_valid), 16'(exp_valid));
      chk("m_busy", 16'(busy), 16'(exp_busy));
      chk("m_err", 16'(frame_err), 16'(exp_err));
      chk("m_ovr", 16'(overrun), 16'(exp_ovr));
      chk("m_code", 16'(err_code), 16'(exp_code));
      if (exp_valid) begin
        chk("m_len", 16'(frame_len), 16'(exp_len));
        if (rd_addr < exp_len) chk("m_rd", 16'(rd_data), 16'(exp_mem[rd_addr]));
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic e = 1'b0);
    @(posedge clk); #2;
    rx_data = b; rx_error = e; rx_done = 1'b1;
    @(posedge clk); #2;
    rx_done = 1'b0; rx_error = 1'b0;
  endtask

  task automatic ack(input logic with_byte = 1'b0);
    @(posedge clk); #2;
    frame_ack = 1'b1; rx_done = with_byte; rx_data = 8'h99;
    @(posedge clk); #2;
    frame_ack = 1'b0; rx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] v);
    rd_addr = a; #1;
    chk(name, 16'(rd_data), 16'(v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #2;
  endtask

  initial begin
    idle(3);
    chk("rst_valid", 16'(frame_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_code", 16'(err_code), 16'd0);
    reset = 1'b0;
    idle(2);

    // Good 3-byte frame
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("f1_notyet", 16'(frame_valid), 16'd0);
    send(8'h03);
    chk("f1_valid", 16'(frame_valid), 16'd1);
    chk("f1_len", 16'(frame_len), 16'd3);
    read_chk("f1_rd0", 4'd0, 8'h11);
    read_chk("f1_rd1", 4'd1, 8'h22);
    read_chk("f1_rd2", 4'd2, 8'h33);
    ack();
    chk("f1_ackv", 16'(frame_valid), 16'd0);
    chk("f1_ackb", 16'(busy), 16'd0);

    // Bad checksum
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    chk("f2_err", 16'(frame_err), 16'd1);
    chk("f2_code", 16'(err_code), 16'd0);
    chk("f2_busy", 16'(busy), 16'd0);
    chk("f2_valid", 16'(frame_valid), 16'd0);

    // Over-length, then noise and an empty frame
    send(8'hA5); send(8'h10);
    chk("f3_err", 16'(frame_err), 16'd1);
    chk("f3_code", 16'(err_code), 16'd1);
    send(8'h55); send(8'hA5); send(8'h00); send(8'h00);
    chk("f4_valid", 16'(frame_valid), 16'd1);
    chk("f4_len", 16'(frame_len), 16'd0);
    ack();

    // Overrun while holding
    send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h64);
    chk("f5_valid", 16'(frame_valid), 16'd1);
    read_chk("f5_rd1", 4'd1, 8'hCD);
    send(8'h01);
    chk("f5_ovr1", 16'(overrun), 16'd1);
    send(8'h02);
    chk("f5_ovr2", 16'(overrun), 16'd1);
    read_chk("f5_rd1b", 4'd1, 8'hCD);
    read_chk("f5_rd0b", 4'd0, 8'hAB);
    ack(1'b1);
    chk("f5_ovr3", 16'(overrun), 16'd1);
    chk("f5_ackv", 16'(frame_valid), 16'd0);

    // Stop-bit error: abort mid-frame, ignored in hunt
    send(8'hA5, 1'b1);
    chk("e_hunt_busy", 16'(busy), 16'd0);
    send(8'hA5); send(8'h02); send(8'h44, 1'b1);
    chk("e_err", 16'(frame_err), 16'd1);
    chk("e_code", 16'(err_code), 16'd2);

    // Maximum length frame
    send(8'hA5); send(8'h0F);
    for (int i = 0; i < 15; i++) send(8'(i * 17));
    send(8'hF0);
    chk("f6_valid", 16'(frame_valid), 16'd1);
    chk("f6_len", 16'(frame_len), 16'd15);
    read_chk("f6_rd14", 4'd14, 8'hEE);
    read_chk("f6_rd7", 4'd7, 8'h77);
    ack();

    // Reset while holding and mid-frame
    send(8'hA5); send(8'h01); send(8'h77); send(8'h76);
    chk("f7_valid", 16'(frame_valid), 16'd1);
    do_reset();
    chk("r_hold_valid", 16'(frame_valid), 16'd0);
    chk("r_hold_err", 16'(frame_err), 16'd0);

    // Inter-byte gap
    send(8'hA5); send(8'h02); send(8'h10);
    idle(int'(TO) + 5);
`ifdef UART_FRAME_TIMEOUT_EN
    chk("to_code", 16'(err_code), 16'd3);
    chk("to_busy", 16'(busy), 16'd0);
`else
    chk("to_busy", 16'(busy), 16'd1);
`endif
    do_reset();
    chk("r_busy", 16'(busy), 16'd0);
    chk("r_err", 16'(frame_err), 16'd0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
